// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: request ops, FSM states,
// and the error-cause bit positions with the helper that evaluates them.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    OP_WORD = 2'b00,
    OP_SWL  = 2'b01,
    OP_SWR  = 2'b10,
    OP_RSVD = 2'b11
  } dmem_op_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT
  } dmem_state_e;

  localparam int ERR_RANGE  = 0;
  localparam int ERR_ALIGN  = 1;
  localparam int ERR_OP     = 2;
  localparam int ERR_DIR    = 3;
  localparam int ERR_CAUSES = 4;

  // Any set bit means the request is rejected without touching memory.
  function automatic logic [ERR_CAUSES-1:0] err_causes(
    input logic        write,
    input dmem_op_e    op,
    input logic [31:0] addr,
    input int          addr_width
  );
    logic [ERR_CAUSES-1:0] c;
    c            = '0;
    c[ERR_RANGE] = (addr >> (addr_width + 2)) != 32'd0;
    c[ERR_ALIGN] = (op == OP_WORD) && (addr[1:0] != 2'b00);
    c[ERR_OP]    = (op == OP_RSVD);
    c[ERR_DIR]   = ((op == OP_SWL) || (op == OP_SWR)) && !write;
    return c;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores: turns op and byte offset into a byte enable
// and store data shifted onto the lanes being written.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  dmem_op_e    op,
  input  logic [1:0]  k,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] data
);

  // For SWL, ~k equals 3-k: the top k+1 source bytes land on lanes k..0.
  always_comb begin
    be   = '0;
    data = wdata;
    case (op)
      OP_WORD: be = 4'hF;
      OP_SWL: begin
        be   = 4'hF >> ~k;
        data = wdata >> {~k, 3'b000};
      end
      OP_SWR: begin
        be   = 4'hF << k;
        data = wdata << {k, 3'b000};
      end
      default: be = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: one request at a time,
// programmable wait states, single-cycle response pulse.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_INIT   | clearing memory one word per cycle, req_ready low
// ST_IDLE   | req_ready high, latch request on req_valid
// ST_WAIT   | down-counting wait states, requests ignored
// ST_COMMIT | response visible; memory write lands on the closing edge
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [31:0]           mem [DEPTH];
  dmem_state_e           state;
  logic [ADDR_WIDTH-1:0] init_idx;
  logic [CW-1:0]         wait_cnt;
  logic                  write_q;
  dmem_op_e              op_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;

  // Response is registered on the edge entering COMMIT; with no wait states
  // that edge is the accept edge, so the request fields come straight from the port.
  logic                  cur_write;
  dmem_op_e              cur_op;
  logic [31:0]           cur_addr;
  logic [ERR_CAUSES-1:0] cur_causes;
  logic                  cur_err;
  logic [ADDR_WIDTH-1:0] cur_idx;

  always_comb begin
    cur_write = write_q;
    cur_op    = op_q;
    cur_addr  = addr_q;
    if (state == ST_IDLE) begin
      cur_write = req_write;
      cur_op    = dmem_op_e'(req_op);
      cur_addr  = req_addr;
    end
  end

  assign cur_causes = err_causes(cur_write, cur_op, cur_addr, ADDR_WIDTH);
  assign cur_err    = |cur_causes;
  assign cur_idx    = cur_addr[ADDR_WIDTH+1:2];

  logic [3:0]  lane_be;
  logic [31:0] lane_data;

  dmem_lane_align u_lane_align (
    .op    (op_q),
    .k     (addr_q[1:0]),
    .wdata (wdata_q),
    .be    (lane_be),
    .data  (lane_data)
  );

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;

  always_comb begin
    mem_we  = 1'b0;
    wr_idx  = init_idx;
    wr_be   = 4'hF;
    wr_data = '0;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_we = 1'b1;
      end else if ((state == ST_COMMIT) && write_q && !cur_err) begin
        mem_we  = 1'b1;
        wr_idx  = addr_q[ADDR_WIDTH+1:2];
        wr_be   = lane_be;
        wr_data = lane_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      init_idx   <= '0;
      wait_cnt   <= '0;
      write_q    <= 1'b0;
      op_q       <= OP_WORD;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            op_q      <= dmem_op_e'(req_op);
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state      <= ST_COMMIT;
              resp_valid <= 1'b1;
              resp_err   <= cur_err;
              resp_rdata <= (cur_err || cur_write) ? 32'd0 : mem[cur_idx];
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= CW'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == CW'(1)) begin
            state      <= ST_COMMIT;
            resp_valid <= 1'b1;
            resp_err   <= cur_err;
            resp_rdata <= (cur_err || cur_write) ? 32'd0 : mem[cur_idx];
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_COMMIT: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responder builds (2, 3 and 0 wait states) run in
// parallel against a byte-level memory model and hand-derived expectations.
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int WA = 2;
  localparam int WB = 3;
  localparam int WC = 0;

  int n_checks = 0;
  int n_pass   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_valid, a_ready, a_write, a_rvalid, a_err;
  logic [1:0]  a_op;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_reset, b_valid, b_ready, b_write, b_rvalid, b_err;
  logic [1:0]  b_op;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        c_reset, c_valid, c_ready, c_write, c_rvalid, c_err;
  logic [1:0]  c_op;
  logic [31:0] c_addr, c_wdata, c_rdata;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WA)) u_dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_op(a_op), .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err));

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WB)) u_dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_op(b_op), .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err));

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) u_dut_c (
    .clk(clk), .reset(c_reset), .req_valid(c_valid), .req_ready(c_ready),
    .req_write(c_write), .req_op(c_op), .req_addr(c_addr), .req_wdata(c_wdata),
    .resp_valid(c_rvalid), .resp_rdata(c_rdata), .resp_err(c_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  logic [31:0] model_mem [1 << AW];

  // Reference behaviour written byte by byte from the store rules.
  task automatic model_access(input logic w, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] rd, output logic er);
    int k, wi;
    k  = int'(a[1:0]);
    wi = int'(a[AW+1:2]);
    er = (a >= 32'(1 << (AW + 2))) || (op == 2'b00 && k != 0) || (op == 2'b11) ||
         (op != 2'b00 && !w);
    rd = '0;
    if (er) return;
    if (!w) rd = model_mem[wi];
    else if (op == 2'b00) model_mem[wi] = d;
    else if (op == 2'b01) for (int i = 0; i <= k; i++) model_mem[wi][8*(k-i) +: 8] = d[8*(3-i) +: 8];
    else for (int i = 0; i <= 3 - k; i++) model_mem[wi][8*(k+i) +: 8] = d[8*i +: 8];
  endtask

  task automatic req_a(input logic w, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n, lat;
    logic [31:0] erd;
    logic eer;
    n = 0;
    while (!a_ready && n < 2000) begin @(negedge clk); n++; end
    if (!a_ready) begin
      check("a_ready_timeout", {31'd0, a_ready}, 32'd1);
      rd = '0; er = 1'b0;
      return;
    end
    a_valid = 1'b1; a_write = w; a_op = op; a_addr = a; a_wdata = d;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    lat = 1;
    while (!a_rvalid && lat < 20) begin @(negedge clk); lat++; end
    check("a_latency", 32'(lat), 32'(WA + 1));
    rd = a_rdata;
    er = a_err;
    model_access(w, op, a, d, erd, eer);
    check("a_rdata", rd, erd);
    check("a_err", {31'd0, er}, {31'd0, eer});
    @(negedge clk);
    check("a_pulse_clear", {29'd0, a_rvalid, a_err, |a_rdata}, 32'd0);
  endtask

  task automatic run_a();
    logic [31:0] rd;
    logic er;
    logic [1:0] op;
    logic [31:0] a;
    int cyc;
    a_reset = 1'b1; a_valid = 1'b0; a_write = 1'b0; a_op = 2'b00; a_addr = '0; a_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_reset_ready", {31'd0, a_ready}, 32'd0);
    check("a_reset_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("a_reset_rdata", a_rdata, 32'd0);
    check("a_reset_err", {31'd0, a_err}, 32'd0);
    a_reset = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!a_ready && cyc < 3000);
    check("a_init_cycles", 32'(cyc), 32'd1024);
    @(negedge clk);

    req_a(1'b0, 2'b00, 32'h10, 32'h0, rd, er);
    check("a_read_after_init", rd, 32'h0);
    req_a(1'b1, 2'b00, 32'h20, 32'hDEADBEEF, rd, er);
    check("a_write_err", {31'd0, er}, 32'd0);
    req_a(1'b0, 2'b00, 32'h20, 32'h0, rd, er);
    check("a_word_roundtrip", rd, 32'hDEADBEEF);
    req_a(1'b1, 2'b00, 32'h40, 32'h11223344, rd, er);
    req_a(1'b1, 2'b01, 32'h41, 32'hAABBCCDD, rd, er);
    req_a(1'b0, 2'b00, 32'h40, 32'h0, rd, er);
    check("a_swl_word", rd, 32'h1122AABB);
    req_a(1'b1, 2'b00, 32'h40, 32'h11223344, rd, er);
    req_a(1'b1, 2'b10, 32'h42, 32'hAABBCCDD, rd, er);
    req_a(1'b0, 2'b00, 32'h40, 32'h0, rd, er);
    check("a_swr_word", rd, 32'hCCDD3344);
    req_a(1'b0, 2'b00, 32'h22, 32'h0, rd, er);
    check("a_misaligned_err", {31'd0, er}, 32'd1);
    req_a(1'b1, 2'b00, 32'h1000, 32'hFFFFFFFF, rd, er);
    check("a_range_err", {31'd0, er}, 32'd1);
    req_a(1'b0, 2'b00, 32'h0, 32'h0, rd, er);
    check("a_range_no_write", rd, 32'h0);
    req_a(1'b0, 2'b11, 32'h44, 32'h0, rd, er);
    check("a_reserved_err", {31'd0, er}, 32'd1);
    req_a(1'b0, 2'b01, 32'h41, 32'h0, rd, er);
    check("a_swl_read_err", {31'd0, er}, 32'd1);

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      req_a(1'($urandom_range(0, 1)), op, a, $urandom, rd, er);
    end
  endtask

  task automatic run_b();
    logic [9:0] acc_mask, resp_mask, exp_acc, exp_resp;
    int n, seen, lat;
    b_reset = 1'b1; b_valid = 1'b0; b_write = 1'b0; b_op = 2'b00; b_addr = 32'h4; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    b_reset = 1'b0;
    n = 0;
    while (!b_ready && n < 3000) begin @(negedge clk); n++; end
    check("b_init_ready", {31'd0, b_ready}, 32'd1);

    acc_mask = '0; resp_mask = '0; exp_acc = '0; exp_resp = '0;
    b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (b_ready) acc_mask[i] = 1'b1;
      if (b_rvalid) resp_mask[i] = 1'b1;
      @(negedge clk);
    end
    b_valid = 1'b0;
    for (int t = 0; t < 10; t += WB + 2) begin
      exp_acc[t] = 1'b1;
      if (t + WB + 1 < 10) exp_resp[t + WB + 1] = 1'b1;
    end
    check("b_accept_mask", {22'd0, acc_mask}, {22'd0, exp_acc});
    check("b_resp_mask", {22'd0, resp_mask}, {22'd0, exp_resp});

    n = 0;
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h30; b_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    b_reset = 1'b1;
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    seen = 0;
    n = 0;
    while (!b_ready && n < 3000) begin
      @(negedge clk);
      if (b_rvalid) seen++;
      n++;
    end
    check("b_abort_no_resp", 32'(seen), 32'd0);
    check("b_reinit_ready", {31'd0, b_ready}, 32'd1);

    b_valid = 1'b1; b_write = 1'b0; b_addr = 32'h30;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    lat = 1;
    while (!b_rvalid && lat < 20) begin @(negedge clk); lat++; end
    check("b_latency", 32'(lat), 32'(WB + 1));
    check("b_abort_word", b_rdata, 32'h0);
    check("b_abort_err", {31'd0, b_err}, 32'd0);
  endtask

  task automatic run_c();
    int n;
    c_reset = 1'b1; c_valid = 1'b0; c_write = 1'b0; c_op = 2'b00; c_addr = '0; c_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    c_reset = 1'b0;
    n = 0;
    while (!c_ready && n < 3000) begin @(negedge clk); n++; end
    check("c_init_ready", {31'd0, c_ready}, 32'd1);

    c_valid = 1'b1; c_write = 1'b1; c_op = 2'b00; c_addr = 32'h8; c_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    check("c_write_lat1", {31'd0, c_rvalid}, 32'd1);
    check("c_write_err", {31'd0, c_err}, 32'd0);
    @(negedge clk);
    c_valid = 1'b1; c_write = 1'b1; c_op = 2'b10; c_addr = 32'hB; c_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    check("c_swr_lat1", {31'd0, c_rvalid}, 32'd1);
    @(negedge clk);
    c_valid = 1'b1; c_write = 1'b0; c_op = 2'b00; c_addr = 32'h8;
    @(posedge clk);
    @(negedge clk);
    c_valid = 1'b0;
    check("c_read_lat1", {31'd0, c_rvalid}, 32'd1);
    check("c_read_data", c_rdata, 32'hDD345678);
    @(negedge clk);
    check("c_pulse_clear", {31'd0, c_rvalid}, 32'd0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish by time limit, expected bench completion");
    $fatal(1);
  end

endmodule
